// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SPI flash read arbiter and its mem_read users.
package mem_arb_pkg;

  localparam int ADDR_W          = 24;
  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 2047;
  localparam int TO_CNT_W        = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RESP  = 3'd2,
    ST_HIT   = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_t;

  // Timeout counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [TO_CNT_W-1:0] sat_inc(input logic [TO_CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + TO_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/mem_hit_buf.sv
// One-entry instruction hit buffer; invalidated only by reset or a transaction timeout.
module mem_hit_buf
  import mem_arb_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv
);

  logic              buf_valid_r;
  logic [ADDR_W-1:0] buf_addr_r;
  logic [DATA_W-1:0] buf_data_r;

  // Buffer entry; invalidation takes priority over a write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_r <= 1'b0;
      buf_addr_r  <= {ADDR_W{1'b0}};
      buf_data_r  <= {DATA_W{1'b0}};
    end else if (inv) begin
      buf_valid_r <= 1'b0;
    end else if (wr_en) begin
      buf_valid_r <= 1'b1;
      buf_addr_r  <= wr_addr;
      buf_data_r  <= wr_data;
    end
  end

  assign hit     = EN && buf_valid_r && (buf_addr_r == lookup_addr);
  assign rd_data = buf_data_r;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem_read SPI engine between the fetch and load ports,
// with start/done sequencing, a post-transaction low gap, a hit buffer and timeout abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter bit HIT_BUF_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  output logic              if_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic              mem_start_fetch,
  output logic [ADDR_W-1:0] mem_target_address,
  input  logic [DATA_W-1:0] mem_fetched_data,
  input  logic              mem_fetch_done,
  output logic              busy
);

  localparam int                  GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          state_r, state_next_s;
  logic [TO_CNT_W-1:0] cnt_r, cnt_next_s;
  logic [GAP_W-1:0]    gap_r, gap_next_s;
  logic                gnt_ld_r, gnt_ld_next_s;
  logic                last_ld_r, last_ld_next_s;
  logic                start_r, start_next_s;
  logic [ADDR_W-1:0]   taddr_r, taddr_next_s;
  logic                if_ack_r, if_ack_next_s, ld_ack_r, ld_ack_next_s;
  logic                if_err_r, if_err_next_s, ld_err_r, ld_err_next_s;
  logic [DATA_W-1:0]   if_data_r, if_data_next_s, ld_data_r, ld_data_next_s;
  logic                hit_s, wr_en_s, inv_s, pick_ld_s;
  logic [DATA_W-1:0]   buf_data_s;

  mem_hit_buf #(.EN(HIT_BUF_EN)) u_hit_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_addr(if_addr),
    .hit        (hit_s),
    .rd_data    (buf_data_s),
    .wr_en      (wr_en_s),
    .wr_addr    (taddr_r),
    .wr_data    (if_data_r),
    .inv        (inv_s)
  );

  // Load wins unless instruction is also requesting and load was served last.
  assign pick_ld_s = ld_req && (!if_req || !last_ld_r);

  // Next-state and next-output logic; acks are set on the edge entering RESP/HIT
  // so each pulse occupies exactly the RESP or HIT cycle.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    gap_next_s     = gap_r;
    gnt_ld_next_s  = gnt_ld_r;
    last_ld_next_s = last_ld_r;
    start_next_s   = start_r;
    taddr_next_s   = taddr_r;
    if_ack_next_s  = 1'b0;
    ld_ack_next_s  = 1'b0;
    if_err_next_s  = 1'b0;
    ld_err_next_s  = 1'b0;
    if_data_next_s = if_data_r;
    ld_data_next_s = ld_data_r;
    wr_en_s        = 1'b0;
    inv_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (if_req || ld_req) begin
          if (!pick_ld_s && hit_s) begin
            if_ack_next_s  = 1'b1;
            if_data_next_s = buf_data_s;
            state_next_s   = ST_HIT;
          end else begin
            gnt_ld_next_s = pick_ld_s;
            taddr_next_s  = pick_ld_s ? ld_addr : if_addr;
            start_next_s  = 1'b1;
            cnt_next_s    = {TO_CNT_W{1'b0}};
            state_next_s  = ST_FETCH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        cnt_next_s = sat_inc(cnt_r);
        if (mem_fetch_done) begin
          start_next_s = 1'b0;
          state_next_s = ST_RESP;
          if (gnt_ld_r) begin
            ld_ack_next_s  = 1'b1;
            ld_data_next_s = mem_fetched_data;
          end else begin
            if_ack_next_s  = 1'b1;
            if_data_next_s = mem_fetched_data;
          end
        end else if (cnt_r >= TO_LAST) begin
          start_next_s = 1'b0;
          state_next_s = ST_RESP;
          inv_s        = 1'b1;
          if (gnt_ld_r) begin
            ld_ack_next_s  = 1'b1;
            ld_err_next_s  = 1'b1;
            ld_data_next_s = {DATA_W{1'b0}};
          end else begin
            if_ack_next_s  = 1'b1;
            if_err_next_s  = 1'b1;
            if_data_next_s = {DATA_W{1'b0}};
          end
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_RESP: begin
        if (!gnt_ld_r && !if_err_r) begin
          wr_en_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
        last_ld_next_s = gnt_ld_r;
        gap_next_s     = {GAP_W{1'b0}};
        state_next_s   = ST_GAP;
      end
      ST_HIT: begin
        last_ld_next_s = 1'b0;
        state_next_s   = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          gap_next_s = gap_r + GAP_W'(1);
        end
      end
      default: begin
        start_next_s = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered datapath and port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {TO_CNT_W{1'b0}};
      gap_r     <= {GAP_W{1'b0}};
      gnt_ld_r  <= 1'b0;
      last_ld_r <= 1'b0;
      start_r   <= 1'b0;
      taddr_r   <= {ADDR_W{1'b0}};
      if_ack_r  <= 1'b0;
      ld_ack_r  <= 1'b0;
      if_err_r  <= 1'b0;
      ld_err_r  <= 1'b0;
      if_data_r <= {DATA_W{1'b0}};
      ld_data_r <= {DATA_W{1'b0}};
    end else begin
      cnt_r     <= cnt_next_s;
      gap_r     <= gap_next_s;
      gnt_ld_r  <= gnt_ld_next_s;
      last_ld_r <= last_ld_next_s;
      start_r   <= start_next_s;
      taddr_r   <= taddr_next_s;
      if_ack_r  <= if_ack_next_s;
      ld_ack_r  <= ld_ack_next_s;
      if_err_r  <= if_err_next_s;
      ld_err_r  <= ld_err_next_s;
      if_data_r <= if_data_next_s;
      ld_data_r <= ld_data_next_s;
    end
  end

  assign if_ack             = if_ack_r;
  assign if_err             = if_err_r;
  assign if_data            = if_data_r;
  assign ld_ack             = ld_ack_r;
  assign ld_err             = ld_err_r;
  assign ld_data            = ld_data_r;
  assign mem_start_fetch    = start_r;
  assign mem_target_address = taddr_r;
  assign busy               = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized traffic against a transaction-level
// model of arbitration, hit buffer, latency and timeout, plus a short-timeout instance.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int GAP = 2;
  localparam int T1  = 2047;
  localparam int T2  = 1040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, ld_req, if_ack, ld_ack, if_err, ld_err;
  logic [23:0] if_addr, ld_addr, mem_target_address;
  logic [31:0] if_data, ld_data;
  logic        mem_start_fetch, busy;
  logic        mem_fetch_done = 1'b0;
  logic [31:0] mem_fetched_data = 32'h0;

  logic        if_req2, ld_req2, if_ack2, ld_ack2, if_err2, ld_err2, start2, busy2;
  logic [23:0] if_addr2, ld_addr2, taddr2;
  logic [31:0] if_data2, ld_data2;
  logic        done2 = 1'b0;
  logic [31:0] data2 = 32'h0;

  mem_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(T1), .HIT_BUF_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_data(ld_data), .ld_err(ld_err),
    .mem_start_fetch(mem_start_fetch), .mem_target_address(mem_target_address),
    .mem_fetched_data(mem_fetched_data), .mem_fetch_done(mem_fetch_done), .busy(busy)
  );

  mem_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(T2), .HIT_BUF_EN(1'b1)) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_data(if_data2), .if_err(if_err2),
    .ld_req(ld_req2), .ld_addr(ld_addr2), .ld_ack(ld_ack2), .ld_data(ld_data2), .ld_err(ld_err2),
    .mem_start_fetch(start2), .mem_target_address(taddr2),
    .mem_fetched_data(data2), .mem_fetch_done(done2), .busy(busy2)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] salt;

  // Flash contents seen by both engines.
  function automatic logic [31:0] flash_data(input logic [23:0] a);
    if (a == 24'h000010) return 32'hDEADBEEF;
    return {a[7:0], a} ^ salt;
  endfunction

  // Reference model state: last served port and the buffered instruction word.
  bit          m_last_ld = 1'b0;
  bit          m_valid   = 1'b0;
  logic [23:0] m_addr    = 24'h0;
  logic [31:0] m_data    = 32'h0;

  // mem_read model and start/gap/ack monitors for the main instance.
  int          flash_lat = 10;
  bit          flash_hang = 1'b0;
  int          fl_cnt = 0;
  int          starts = 0;
  int          low_run = 0;
  int          gap_viol = 0;
  int          if_acks = 0;
  bit          seen_txn = 1'b0;
  logic        start_prev = 1'b0;
  logic [23:0] last_start_addr = 24'h0;

  always @(negedge clk) begin
    if (mem_start_fetch && !start_prev) begin
      starts++;
      last_start_addr = mem_target_address;
      if (seen_txn && low_run < GAP) gap_viol++;
      seen_txn = 1'b1;
    end
    if (mem_start_fetch) low_run = 0;
    else low_run++;
    start_prev = mem_start_fetch;
    if (if_ack) if_acks++;
    if (!mem_start_fetch) begin
      fl_cnt = 0;
      mem_fetch_done = 1'b0;
    end else begin
      fl_cnt++;
      mem_fetch_done = !flash_hang && (fl_cnt == flash_lat);
      if (mem_fetch_done) mem_fetched_data = flash_data(mem_target_address);
    end
  end

  // mem_read model for the short-timeout instance.
  int lat2 = T2;
  int c2 = 0;
  always @(negedge clk) begin
    if (!start2) begin
      c2 = 0;
      done2 = 1'b0;
    end else begin
      c2++;
      done2 = (c2 == lat2);
      if (done2) data2 = flash_data(taddr2);
    end
  end

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s idle_wait: busy=%b want 0", tag, busy); end
  endtask

  task automatic single_req(input bit is_ld, input logic [23:0] addr, input int budget,
                            output int lat, output logic [31:0] d, output logic e, output bit got);
    got = 1'b0; lat = 0; d = 32'hx; e = 1'bx;
    if (is_ld) begin ld_addr = addr; ld_req = 1'b1; end
    else begin if_addr = addr; if_req = 1'b1; end
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (is_ld ? ld_ack : if_ack) begin
        got = 1'b1; lat = k;
        d = is_ld ? ld_data : if_data;
        e = is_ld ? ld_err : if_err;
        break;
      end
    end
    if_req = 1'b0; ld_req = 1'b0;
  endtask

  // One request on one port, checked against the model's predicted outcome.
  task automatic run_txn(input bit is_ld, input logic [23:0] addr, input int lat_cfg,
                         input bit hang, input string tag);
    bit exp_hit; int exp_lat; logic [31:0] exp_data; logic exp_err;
    int s0; int lat; logic [31:0] d; logic e; bit got;
    exp_hit = !is_ld && m_valid && (addr == m_addr);
    if (exp_hit) begin
      exp_lat = 1; exp_data = m_data; exp_err = 1'b0;
    end else if (hang) begin
      exp_lat = T1 + 1; exp_data = 32'h0; exp_err = 1'b1; m_valid = 1'b0;
    end else begin
      exp_lat = lat_cfg + 1; exp_data = flash_data(addr); exp_err = 1'b0;
      if (!is_ld) begin m_valid = 1'b1; m_addr = addr; m_data = exp_data; end
    end
    m_last_ld = is_ld;
    wait_idle(tag);
    flash_lat = lat_cfg; flash_hang = hang; s0 = starts;
    single_req(is_ld, addr, exp_lat + 20, lat, d, e, got);
    checks++;
    if (!got || lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
    checks++;
    if (d !== exp_data) begin errors++; $display("FAIL %s data: got %h want %h", tag, d, exp_data); end
    checks++;
    if (e !== exp_err) begin errors++; $display("FAIL %s err: got %b want %b", tag, e, exp_err); end
    checks++;
    if (starts - s0 != (exp_hit ? 0 : 1)) begin
      errors++; $display("FAIL %s spi_starts: got %0d want %0d", tag, starts - s0, exp_hit ? 0 : 1);
    end
    if (!exp_hit) begin
      checks++;
      if (last_start_addr !== addr) begin errors++; $display("FAIL %s target_addr: got %h want %h", tag, last_start_addr, addr); end
    end
  endtask

  // Both ports request together; checks service order and both responses.
  task automatic pair(input logic [23:0] ia, input logic [23:0] la, input int lat_cfg, input string tag);
    bit first_ld, if_hit, if_got, ld_got, first_is_ld;
    logic [31:0] exp_if, exp_ld, gi_d, gl_d;
    logic gi_e, gl_e;
    int exp_starts, s0;
    first_ld = !m_last_ld;
    exp_ld = flash_data(la);
    if_hit = m_valid && (ia == m_addr);
    exp_if = if_hit ? m_data : flash_data(ia);
    exp_starts = if_hit ? 1 : 2;
    if (!if_hit) begin m_valid = 1'b1; m_addr = ia; m_data = exp_if; end
    m_last_ld = !first_ld;
    wait_idle(tag);
    flash_lat = lat_cfg; flash_hang = 1'b0; s0 = starts;
    if_got = 1'b0; ld_got = 1'b0; first_is_ld = 1'b0;
    gi_d = 32'hx; gl_d = 32'hx; gi_e = 1'bx; gl_e = 1'bx;
    if_addr = ia; ld_addr = la; if_req = 1'b1; ld_req = 1'b1;
    for (int k = 0; k < 3 * (lat_cfg + 10); k++) begin
      @(negedge clk);
      if (if_ack && !if_got) begin
        if (!ld_got) first_is_ld = 1'b0;
        if_got = 1'b1; gi_d = if_data; gi_e = if_err; if_req = 1'b0;
      end
      if (ld_ack && !ld_got) begin
        if (!if_got) first_is_ld = 1'b1;
        ld_got = 1'b1; gl_d = ld_data; gl_e = ld_err; ld_req = 1'b0;
      end
      if (if_got && ld_got) break;
    end
    if_req = 1'b0; ld_req = 1'b0;
    checks++;
    if (!(if_got && ld_got)) begin errors++; $display("FAIL %s both_acked: if=%b ld=%b want 1 1", tag, if_got, ld_got); end
    checks++;
    if (first_is_ld != first_ld) begin errors++; $display("FAIL %s order: first_ld=%b want %b", tag, first_is_ld, first_ld); end
    checks++;
    if (gi_d !== exp_if || gi_e !== 1'b0) begin errors++; $display("FAIL %s if_resp: got %h/%b want %h/0", tag, gi_d, gi_e, exp_if); end
    checks++;
    if (gl_d !== exp_ld || gl_e !== 1'b0) begin errors++; $display("FAIL %s ld_resp: got %h/%b want %h/0", tag, gl_d, gl_e, exp_ld); end
    checks++;
    if (starts - s0 != exp_starts) begin errors++; $display("FAIL %s spi_starts: got %0d want %0d", tag, starts - s0, exp_starts); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_ack, ld_ack, if_err, ld_err, mem_start_fetch, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {if_ack, ld_ack, if_err, ld_err, mem_start_fetch, busy});
    end
    checks++;
    if ({if_data, ld_data, mem_target_address} !== 88'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0", if_data, ld_data, mem_target_address);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_start_fetch !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b start=%b want 0 0", busy, mem_start_fetch);
    end
  endtask

  task automatic test_tie_break();
    pair(24'h000020, 24'h000100, 12, "tie_first");
    run_txn(1'b1, 24'h000104, 8, 1'b0, "tie_lone_ld");
    pair(24'h000024, 24'h000108, 12, "tie_second");
  endtask

  task automatic test_miss_and_hit();
    run_txn(1'b0, 24'h000010, 1040, 1'b0, "single_miss");
    run_txn(1'b0, 24'h000010, 1040, 1'b0, "hit");
  endtask

  task automatic test_timeout();
    logic [23:0] saved;
    saved = m_addr;
    checks++;
    if (!m_valid) begin errors++; $display("FAIL timeout_setup: model buffer valid=%b want 1", m_valid); end
    run_txn(1'b1, 24'h000044, 0, 1'b1, "timeout");
    run_txn(1'b0, saved, 20, 1'b0, "after_timeout");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [23:0] a;
      int lat;
      a = 24'h000800 + 24'($urandom_range(0, 3) * 4);
      lat = $urandom_range(2, 30);
      if ($urandom_range(0, 3) == 0) pair(a, 24'($urandom), lat, "rand_pair");
      else run_txn(1'($urandom_range(0, 1)), a, lat, 1'b0, "rand_txn");
    end
  endtask

  task automatic test_reset_midop();
    int a0;
    bit seen = 1'b0;
    run_txn(1'b0, 24'h000500, 10, 1'b0, "pre_reset_fill");
    wait_idle("midop");
    flash_hang = 1'b1;
    if_addr = 24'h000300; if_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_start_fetch) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midop_start: start=%b want 1", mem_start_fetch); end
    repeat (500) @(negedge clk);
    a0 = if_acks;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_start_fetch !== 1'b0 || busy !== 1'b0 || if_ack !== 1'b0) begin
      errors++; $display("FAIL midop_async: start=%b busy=%b ack=%b want 0 0 0", mem_start_fetch, busy, if_ack);
    end
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_last_ld = 1'b0;
    flash_hang = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (if_acks != a0) begin errors++; $display("FAIL midop_no_ack: acks=%0d want %0d", if_acks, a0); end
    run_txn(1'b0, 24'h000500, 10, 1'b0, "post_reset_miss");
  endtask

  task automatic test_done_vs_timeout();
    for (int v = 0; v < 2; v++) begin
      logic [23:0] a;
      logic [31:0] d, exp_d;
      logic e;
      int lat;
      bit got = 1'b0, idle = 1'b0;
      a = 24'h000600 + 24'(v * 4);
      lat2 = T2 + v;
      exp_d = (v == 0) ? flash_data(a) : 32'h0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!busy2) begin idle = 1'b1; break; end
      end
      checks++;
      if (!idle) begin errors++; $display("FAIL dvt_idle: busy2=%b want 0", busy2); end
      lat = 0; d = 32'hx; e = 1'bx;
      if_addr2 = a; if_req2 = 1'b1;
      for (int k = 1; k <= T2 + 30; k++) begin
        @(negedge clk);
        if (if_ack2) begin got = 1'b1; lat = k; d = if_data2; e = if_err2; break; end
      end
      if_req2 = 1'b0;
      checks++;
      if (!got || lat != T2 + 1) begin errors++; $display("FAIL dvt%0d latency: got %0d want %0d", v, lat, T2 + 1); end
      checks++;
      if (d !== exp_d || e !== 1'(v)) begin errors++; $display("FAIL dvt%0d resp: got %h/%b want %h/%0d", v, d, e, exp_d, v); end
    end
  endtask

  task automatic test_gap();
    checks++;
    if (gap_viol != 0) begin errors++; $display("FAIL start_gap: violations=%0d want 0", gap_viol); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom;
    if_req = 1'b0; ld_req = 1'b0; if_addr = 24'h0; ld_addr = 24'h0;
    if_req2 = 1'b0; ld_req2 = 1'b0; if_addr2 = 24'h0; ld_addr2 = 24'h0;
    test_reset();
    test_tie_break();
    test_miss_and_hit();
    test_timeout();
    test_random();
    test_reset_midop();
    test_done_vs_timeout();
    test_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
